// File: rtl/mod_sub_pipe.sv
// mod_sub_pipe -- pipelined modular subtractor, B = (A - M) mod q.
//
// Two register stages with valid bits:
//   s1 : captures A, M, q on accept (in_valid & in_ready)
//   s2 : holds the reduced result B and out_valid
// The block takes one operation per cycle and can hold up to two under
// downstream backpressure. Results leave in the order they were accepted.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   operand set A/M/q presented
//   in_ready   block can accept this cycle (depends only on state and out_ready)
//   A, M       minuend / subtrahend, expected < q
//   q          modulus, sampled with each transaction
//   out_valid  B holds a result
//   out_ready  downstream consumes B this cycle
//   B          registered result
//   range_err  registered out-of-range flag that travels with B
//
// Build option:
//   MOD_SUB_RANGE_CHECK_EN  when defined, s1 also registers
//                           (A >= q) | (M >= q) | (q == 0), which is piped to
//                           range_err. When undefined, no comparators are built
//                           and range_err is tied to 0.
module mod_sub_pipe #(
  parameter int unsigned WIDTH = 48
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             range_err
);

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_m;
  logic [WIDTH-1:0] s1_q;
  logic             s2_v;
  logic [WIDTH-1:0] b_q;

  logic             accept;
  logic             s2_load;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;

  // s2 can take s1's content when it is empty or being drained this cycle;
  // in_ready follows the same reasoning one stage further up.
  assign s2_load  = s1_v & (~s2_v | out_ready);
  assign in_ready = ~s1_v | ~s2_v | out_ready;
  assign accept   = in_valid & in_ready;

  // Borrow out of the extended subtraction means A < M: fold back by adding q.
  // The sum is truncated to WIDTH; no extra carry bit is kept.
  always_comb begin
    diff   = {1'b0, s1_a} - {1'b0, s1_m};
    result = diff[WIDTH-1:0];
    if (diff[WIDTH]) begin
      result = diff[WIDTH-1:0] + s1_q;
    end
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_m <= '0;
      s1_q <= '0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        s1_a <= A;
        s1_m <= M;
        s1_q <= q;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
    end
  end

  // Stage 2: result register. B only changes on a load, so it is stable
  // while out_valid is held against a low out_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v <= 1'b0;
      b_q  <= '0;
    end else begin
      if (s2_load) begin
        s2_v <= 1'b1;
        b_q  <= result;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = s2_v;
  assign B         = b_q;

`ifdef MOD_SUB_RANGE_CHECK_EN
  logic s1_err;
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_err <= 1'b0;
    end else if (accept) begin
      s1_err <= (A >= q) | (M >= q) | (q == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (s2_load) begin
      err_q <= s1_err;
    end
  end

  assign range_err = err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
